// File: rtl/video_pattern_gen_if.sv
// Pixel stream between the timing generator and the pattern generator.
// There is no backpressure: i_de is the valid qualifier for each pixel and the consumer is always ready.
interface video_pattern_gen_if #(
  parameter int SX_W = 10,
  parameter int SY_W = 10
);
  logic [SX_W-1:0] i_sx;
  logic [SY_W-1:0] i_sy;
  logic            i_hsync;
  logic            i_vsync;
  logic            i_de;
  logic            i_nf;
  logic [1:0]      i_mode;
  logic [7:0]      o_r;
  logic [7:0]      o_g;
  logic [7:0]      o_b;
  logic            o_hsync;
  logic            o_vsync;
  logic            o_de;

  modport master (
    output i_sx, i_sy, i_hsync, i_vsync, i_de, i_nf, i_mode,
    input  o_r, o_g, o_b, o_hsync, o_vsync, o_de
  );

  modport slave (
    input  i_sx, i_sy, i_hsync, i_vsync, i_de, i_nf, i_mode,
    output o_r, o_g, o_b, o_hsync, o_vsync, o_de
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Test-pattern generator: bars, checker, gradient, bouncing box; two-stage pipeline with aligned syncs.
// Optional 1-pixel white frame border when PATTERN_BORDER_EN is defined.
module video_pattern_gen #(
  parameter int ACTIVE_H_PIXELS = 640,
  parameter int ACTIVE_LINES    = 480,
  parameter int SX_W            = 10,
  parameter int SY_W            = 10,
  parameter int BOX_SIZE        = 32,
  parameter int BOX_SPEED       = 2,
  parameter int CHECK_SHIFT     = 5
) (
  input  logic                i_clk_pxl,
  input  logic                i_reset,
  video_pattern_gen_if.slave  vid
);
  localparam int BAR_W = ACTIVE_H_PIXELS / 8;

  localparam logic [SX_W:0] X_ACT = (SX_W+1)'(ACTIVE_H_PIXELS);
  localparam logic [SX_W:0] X_MAX = (SX_W+1)'(ACTIVE_H_PIXELS - BOX_SIZE);
  localparam logic [SX_W:0] X_BOX = (SX_W+1)'(BOX_SIZE);
  localparam logic [SX_W:0] X_SPD = (SX_W+1)'(BOX_SPEED);
  localparam logic [SY_W:0] Y_ACT = (SY_W+1)'(ACTIVE_LINES);
  localparam logic [SY_W:0] Y_MAX = (SY_W+1)'(ACTIVE_LINES - BOX_SIZE);
  localparam logic [SY_W:0] Y_BOX = (SY_W+1)'(BOX_SIZE);
  localparam logic [SY_W:0] Y_SPD = (SY_W+1)'(BOX_SPEED);

  // Frame-rate state
  logic [1:0]      r_mode_q;
  logic [SX_W-1:0] r_box_x;
  logic [SY_W-1:0] r_box_y;
  logic            r_x_dec;
  logic            r_y_dec;

  // Stage 1: pattern predicates
  logic            r_de1;
  logic            r_hs1;
  logic            r_vs1;
  logic [1:0]      r_mode1;
  logic [2:0]      r_bar1;
  logic            r_chk1;
  logic            r_inbox1;
  logic [7:0]      r_gx1;
  logic [7:0]      r_gy1;
`ifdef PATTERN_BORDER_EN
  logic            r_border1;
  logic            w_border;
`endif

  logic [SX_W:0]   w_sx_ext;
  logic [SX_W:0]   w_bx_ext;
  logic [SY_W:0]   w_sy_ext;
  logic [SY_W:0]   w_by_ext;
  logic            w_in_box;
  logic [SX_W-1:0] w_bar_q;
  logic [2:0]      w_bar;
  logic [SX_W-1:0] w_x_next;
  logic            w_x_dec_next;
  logic [SY_W-1:0] w_y_next;
  logic            w_y_dec_next;
  logic [23:0]     w_rgb;

  // One extra bit so box_pos+BOX_SIZE never wraps near the right/bottom edge.
  assign w_sx_ext = {1'b0, vid.i_sx};
  assign w_bx_ext = {1'b0, r_box_x};
  assign w_sy_ext = {1'b0, vid.i_sy};
  assign w_by_ext = {1'b0, r_box_y};
  assign w_in_box = (w_sx_ext >= w_bx_ext) && (w_sx_ext < w_bx_ext + X_BOX) &&
                    (w_sy_ext >= w_by_ext) && (w_sy_ext < w_by_ext + Y_BOX);

  assign w_bar_q = vid.i_sx / SX_W'(BAR_W);
  assign w_bar   = (w_bar_q > SX_W'(7)) ? 3'd7 : w_bar_q[2:0];

`ifdef PATTERN_BORDER_EN
  assign w_border = vid.i_de &&
                    ((vid.i_sx == SX_W'(0)) || (vid.i_sx == SX_W'(ACTIVE_H_PIXELS - 1)) ||
                     (vid.i_sy == SY_W'(0)) || (vid.i_sy == SY_W'(ACTIVE_LINES - 1)));
`endif

  always_comb begin
    w_x_next     = r_box_x;
    w_x_dec_next = r_x_dec;
    if (!r_x_dec) begin
      if (w_bx_ext + X_BOX + X_SPD > X_ACT) begin
        w_x_next     = X_MAX[SX_W-1:0];
        w_x_dec_next = 1'b1;
      end else begin
        w_x_next = r_box_x + SX_W'(BOX_SPEED);
      end
    end else if (w_bx_ext < X_SPD) begin
      w_x_next     = '0;
      w_x_dec_next = 1'b0;
    end else begin
      w_x_next = r_box_x - SX_W'(BOX_SPEED);
    end
  end

  always_comb begin
    w_y_next     = r_box_y;
    w_y_dec_next = r_y_dec;
    if (!r_y_dec) begin
      if (w_by_ext + Y_BOX + Y_SPD > Y_ACT) begin
        w_y_next     = Y_MAX[SY_W-1:0];
        w_y_dec_next = 1'b1;
      end else begin
        w_y_next = r_box_y + SY_W'(BOX_SPEED);
      end
    end else if (w_by_ext < Y_SPD) begin
      w_y_next     = '0;
      w_y_dec_next = 1'b0;
    end else begin
      w_y_next = r_box_y - SY_W'(BOX_SPEED);
    end
  end

  // Bar index bits map straight to channels: white,yellow,cyan,green,magenta,red,blue,black.
  always_comb begin
    w_rgb = '0;
    if (r_de1) begin
      case (r_mode1)
        2'd0:    w_rgb = {{8{~r_bar1[1]}}, {8{~r_bar1[2]}}, {8{~r_bar1[0]}}};
        2'd1:    w_rgb = r_chk1 ? 24'hFFFFFF : 24'h000000;
        2'd2:    w_rgb = {r_gx1, r_gy1, 8'h80};
        default: w_rgb = r_inbox1 ? 24'hFFFFFF : 24'h000040;
      endcase
`ifdef PATTERN_BORDER_EN
      if (r_border1) w_rgb = 24'hFFFFFF;
`endif
    end
  end

  // Mode/box update on the nf edge; stage 1 captures the old values, so pixel (0,0) uses the previous frame.
  always_ff @(posedge i_clk_pxl) begin
    if (i_reset) begin
      r_mode_q    <= '0;
      r_box_x     <= '0;
      r_box_y     <= '0;
      r_x_dec     <= 1'b0;
      r_y_dec     <= 1'b0;
      r_de1       <= 1'b0;
      r_hs1       <= 1'b0;
      r_vs1       <= 1'b0;
      r_mode1     <= '0;
      r_bar1      <= '0;
      r_chk1      <= 1'b0;
      r_inbox1    <= 1'b0;
      r_gx1       <= '0;
      r_gy1       <= '0;
`ifdef PATTERN_BORDER_EN
      r_border1   <= 1'b0;
`endif
      vid.o_r     <= '0;
      vid.o_g     <= '0;
      vid.o_b     <= '0;
      vid.o_hsync <= 1'b0;
      vid.o_vsync <= 1'b0;
      vid.o_de    <= 1'b0;
    end else begin
      if (vid.i_nf) begin
        r_mode_q <= vid.i_mode;
        r_box_x  <= w_x_next;
        r_x_dec  <= w_x_dec_next;
        r_box_y  <= w_y_next;
        r_y_dec  <= w_y_dec_next;
      end
      r_de1       <= vid.i_de;
      r_hs1       <= vid.i_hsync;
      r_vs1       <= vid.i_vsync;
      r_mode1     <= r_mode_q;
      r_bar1      <= w_bar;
      r_chk1      <= vid.i_sx[CHECK_SHIFT] ^ vid.i_sy[CHECK_SHIFT];
      r_inbox1    <= w_in_box;
      r_gx1       <= vid.i_sx[7:0];
      r_gy1       <= vid.i_sy[7:0];
`ifdef PATTERN_BORDER_EN
      r_border1   <= w_border;
`endif
      vid.o_r     <= w_rgb[23:16];
      vid.o_g     <= w_rgb[15:8];
      vid.o_b     <= w_rgb[7:0];
      vid.o_hsync <= r_hs1;
      vid.o_vsync <= r_vs1;
      vid.o_de    <= r_de1;
    end
  end
endmodule
